mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 2048, max BUSY cycles before abort (>=2)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK  in  1  the single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  instruction-port request, held until i_ack or i_err
- i_we  in  1  instruction-port write enable
- i_addr  in  ADDR_W  instruction-port address
- i_wdata  in  DATA_W  instruction-port write data
- i_rdata  out  DATA_W  instruction-port read data
- i_ack  out  1  instruction-port completion pulse
- i_err  out  1  instruction-port timeout pulse
- d_req, d_we, d_addr, d_wdata, d_rdata, d_ack, d_err: data port, same widths and meanings as the i_ signals
- mem_start  out  1  one-cycle transaction start to the external memory controller
- mem_we  out  1  latched write enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  read data; valid when mem_done=1
- mem_done  in  1  one-cycle completion from the controller
- busy  out  1  high in BUSY and DONE
- grant_id  out  1  0=instruction, 1=data; port of current/last grant

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-004 IDLE, no request: state holds, mem_start=0.
REQ-005 IDLE, exactly one request: grant that port at the edge; latch its we/addr/wdata into mem_we/mem_addr/mem_wdata; mem_start=1 for the following cycle only; go BUSY.
REQ-006 IDLE, both requests: round-robin, grant the port != last_grant; last_grant updates to the granted port at grant.
REQ-007 mem_we, mem_addr, mem_wdata SHALL stay stable from grant until the state leaves BUSY.
REQ-008 Timeout counter: 0 on BUSY entry, +1 each BUSY cycle without mem_done.
REQ-009 BUSY with mem_done=1: for a read, load mem_rdata into the granted port's rdata; pulse that port's ack for one cycle; go DONE.
REQ-010 BUSY, mem_done=0, counter == TIMEOUT-1: pulse the granted port's err for one cycle; rdata unchanged; go DONE.
REQ-011 mem_done and timeout in the same cycle: mem_done wins (ack, no err).
REQ-012 DONE: exactly one cycle, no grant evaluated, ack/err fall, then IDLE. The requester drops req on the edge that samples ack/err.
REQ-013 Writes SHALL pulse ack but leave rdata unchanged.
REQ-014 rdata SHALL hold its value until the next completed read on the same port.
REQ-015 mem_done outside BUSY (late after timeout, or spurious) SHALL be ignored: no ack, no rdata update.
REQ-016 Request changes while BUSY/DONE SHALL be ignored; a changed address on the granted port does not alter mem_addr.
REQ-017 Minimum turnaround SHALL be req sampled -> mem_start 1 cycle later; mem_done sampled -> ack 1 cycle later; next grant at the earliest 2 edges after mem_done.
REQ-018 At most one of i_ack, d_ack, i_err, d_err SHALL be high in any cycle.

Reset
REQ-019 On reset assertion, immediately and regardless of state: state=IDLE; last_grant=1 (instruction wins the first tie); counter=0; all outputs 0 (mem_start, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, acks, errs, busy, grant_id).
REQ-020 Reset mid-BUSY SHALL abort the transaction with no ack/err. After release, the first grant occurs on the first edge with a request.

Verification
REQ-021 Single read: i_req=1, i_we=0, i_addr=0x100; mem_done with mem_rdata=0xDEADBEEF 5 cycles after mem_start -> mem_addr=0x100, one mem_start pulse, i_ack one cycle, i_rdata=0xDEADBEEF, d_rdata=0.
REQ-022 Tie after reset: i_req and d_req raised together -> instruction granted first (grant_id=0), data granted 2 cycles after i_ack; a further simultaneous pair alternates I, D, I.
REQ-023 Write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678; on mem_done, d_ack pulse, d_rdata unchanged.
REQ-024 Timeout: TIMEOUT=8, mem_done never asserted -> d_err pulses exactly 8 BUSY cycles after entry; then DONE, IDLE; a late mem_done 3 cycles later produces no ack.
REQ-025 Boundaries: mem_done in the last BUSY cycle (counter=TIMEOUT-1) -> ack, no err; reset asserted mid-BUSY -> all outputs 0 at once, no ack; a new read after release completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (instruction/data) round-robin arbiter onto one memory controller
// Single outstanding transaction; completion or timeout is reported on the granted port.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 2048
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              mem_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy,
  output logic              grant_id
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] count;
  logic             grant_take;
  logic             grant_sel;
  logic             done_take;
  logic             timeout_take;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // On a tie the port that did not win last time is granted.
  always_comb begin
    state_nxt    = state;
    grant_take   = 1'b0;
    grant_sel    = 1'b0;
    done_take    = 1'b0;
    timeout_take = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_take = 1'b1;
          grant_sel  = (i_req && d_req) ? ~last_grant : d_req;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (mem_done) begin
          done_take = 1'b1;
          state_nxt = DONE;
        end else if (count == CNT_LAST) begin
          timeout_take = 1'b1;
          state_nxt    = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      count      <= '0;
      mem_start  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_err      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      mem_start <= grant_take;
      i_ack     <= done_take && !grant_id;
      d_ack     <= done_take && grant_id;
      i_err     <= timeout_take && !grant_id;
      d_err     <= timeout_take && grant_id;
      if (grant_take) begin
        last_grant <= grant_sel;
        grant_id   <= grant_sel;
        count      <= '0;
        mem_we     <= grant_sel ? d_we    : i_we;
        mem_addr   <= grant_sel ? d_addr  : i_addr;
        mem_wdata  <= grant_sel ? d_wdata : i_wdata;
      end else if (state == BUSY && !mem_done) begin
        count <= count + CNT_W'(1);
      end
      // Writes complete with an ack only; rdata keeps the last read result.
      if (done_take && !mem_we) begin
        if (grant_id) begin
          d_rdata <= mem_rdata;
        end else begin
          i_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        reset;
  logic        i_req, i_we, d_req, d_we;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, i_err, d_ack, d_err;
  logic        mem_start, mem_we, mem_done, busy, grant_id;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_i_rdata;
  logic [31:0] exp_d_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .reset(reset),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(busy), .grant_id(grant_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    tick();
    tick();
    n_checks++; if ({mem_start, mem_we, busy, grant_id} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_start, mem_we, busy, grant_id}); end
    n_checks++; if ({i_ack, d_ack, i_err, d_err} !== 4'b0) begin n_fail++; $display("FAIL reset_ackerr: got %b expected 0000", {i_ack, d_ack, i_err, d_err}); end
    n_checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_fail++; $display("FAIL reset_mem: got %h expected 0", {mem_addr, mem_wdata}); end
    n_checks++; if ({i_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata}); end
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    logic extra_start;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h100;
    tick();
    n_checks++; if ({mem_start, busy, grant_id, mem_we} !== 4'b1100) begin n_fail++; $display("FAIL read_grant: got %b expected 1100", {mem_start, busy, grant_id, mem_we}); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL read_addr: got %h expected 00000100", mem_addr); end
    extra_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      extra_start = extra_start | mem_start | i_ack;
    end
    n_checks++; if (extra_start !== 1'b0) begin n_fail++; $display("FAIL read_one_start: got %b expected 0", extra_start); end
    mem_done = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    n_checks++; if ({i_ack, d_ack, i_err, d_err} !== 4'b1000) begin n_fail++; $display("FAIL read_ack: got %b expected 1000", {i_ack, d_ack, i_err, d_err}); end
    n_checks++; if (i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata: got %h expected deadbeef", i_rdata); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL read_d_rdata: got %h expected 0", d_rdata); end
    mem_done = 1'b0; i_req = 1'b0;
    tick();
    n_checks++; if ({i_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL read_after: got %b expected 00", {i_ack, busy}); end
    n_checks++; if (i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_hold: got %h expected deadbeef", i_rdata); end
  endtask

  task automatic test_write;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    tick();
    n_checks++; if ({mem_start, mem_we, grant_id} !== 3'b111) begin n_fail++; $display("FAIL write_grant: got %b expected 111", {mem_start, mem_we, grant_id}); end
    n_checks++; if (mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL write_wdata: got %h expected 12345678", mem_wdata); end
    d_addr = 32'h99; d_wdata = 32'h0;
    tick();
    n_checks++; if ({mem_addr, mem_wdata} !== {32'h20, 32'h12345678}) begin n_fail++; $display("FAIL write_stable: got %h expected 0000002012345678", {mem_addr, mem_wdata}); end
    mem_done = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    n_checks++; if ({i_ack, d_ack, i_err, d_err} !== 4'b0100) begin n_fail++; $display("FAIL write_ack: got %b expected 0100", {i_ack, d_ack, i_err, d_err}); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL write_rdata: got %h expected 0", d_rdata); end
    mem_done = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  task automatic test_tie;
    logic        exp_g;
    logic [31:0] v;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_we = 1'b0; d_we = 1'b0; i_addr = 32'h200; d_addr = 32'h300;
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp_g = n[0];
      v = 32'h1000 + 32'(n);
      tick();
      n_checks++; if ({mem_start, grant_id} !== {1'b1, exp_g}) begin n_fail++; $display("FAIL tie_grant%0d: got %b expected %b", n, {mem_start, grant_id}, {1'b1, exp_g}); end
      n_checks++; if (mem_addr !== (exp_g ? 32'h300 : 32'h200)) begin n_fail++; $display("FAIL tie_addr%0d: got %h expected %h", n, mem_addr, exp_g ? 32'h300 : 32'h200); end
      mem_done = 1'b1; mem_rdata = v;
      tick();
      n_checks++; if ({i_ack, d_ack} !== (exp_g ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL tie_ack%0d: got %b expected %b", n, {i_ack, d_ack}, exp_g ? 2'b01 : 2'b10); end
      n_checks++; if ((exp_g ? d_rdata : i_rdata) !== v) begin n_fail++; $display("FAIL tie_rdata%0d: got %h expected %h", n, exp_g ? d_rdata : i_rdata, v); end
      mem_done = 1'b0;
      if (exp_g) d_req = 1'b0; else i_req = 1'b0;
      tick();
      n_checks++; if ({busy, mem_start} !== 2'b00) begin n_fail++; $display("FAIL tie_idle%0d: got %b expected 00", n, {busy, mem_start}); end
      i_req = 1'b1; d_req = 1'b1;
    end
    i_req = 1'b0; d_req = 1'b0;
    exp_i_rdata = 32'h1004;
    exp_d_rdata = 32'h1003;
  endtask

  task automatic test_timeout;
    logic early_err;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    early_err = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      early_err = early_err | d_err | ~busy;
    end
    n_checks++; if (early_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b expected 0", early_err); end
    tick();
    n_checks++; if ({i_ack, d_ack, i_err, d_err} !== 4'b0001) begin n_fail++; $display("FAIL to_err: got %b expected 0001", {i_ack, d_ack, i_err, d_err}); end
    n_checks++; if (d_rdata !== exp_d_rdata) begin n_fail++; $display("FAIL to_rdata: got %h expected %h", d_rdata, exp_d_rdata); end
    d_req = 1'b0;
    tick();
    n_checks++; if ({d_err, busy} !== 2'b00) begin n_fail++; $display("FAIL to_idle: got %b expected 00", {d_err, busy}); end
    tick();
    tick();
    mem_done = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_done = 1'b0;
    n_checks++; if ({i_ack, d_ack, busy} !== 3'b000) begin n_fail++; $display("FAIL late_done: got %b expected 000", {i_ack, d_ack, busy}); end
    n_checks++; if (d_rdata !== exp_d_rdata) begin n_fail++; $display("FAIL late_rdata: got %h expected %h", d_rdata, exp_d_rdata); end
  endtask

  task automatic test_done_last_cycle;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h500;
    tick();
    for (int k = 1; k <= 7; k++) tick();
    mem_done = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    n_checks++; if ({i_ack, d_ack, i_err, d_err} !== 4'b1000) begin n_fail++; $display("FAIL last_ack: got %b expected 1000", {i_ack, d_ack, i_err, d_err}); end
    n_checks++; if (i_rdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL last_rdata: got %h expected a5a5a5a5", i_rdata); end
    mem_done = 1'b0; i_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    tick();
    n_checks++; if ({busy, grant_id} !== 2'b11) begin n_fail++; $display("FAIL mid_busy: got %b expected 11", {busy, grant_id}); end
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if ({busy, grant_id, mem_start, mem_we} !== 4'b0) begin n_fail++; $display("FAIL mid_ctrl: got %b expected 0000", {busy, grant_id, mem_start, mem_we}); end
    n_checks++; if ({mem_addr, i_rdata, d_rdata} !== 96'h0) begin n_fail++; $display("FAIL mid_data: got %h expected 0", {mem_addr, i_rdata, d_rdata}); end
    mem_done = 1'b1; mem_rdata = 32'h77777777;
    tick();
    mem_done = 1'b0;
    tick();
    n_checks++; if ({i_ack, d_ack, i_err, d_err} !== 4'b0) begin n_fail++; $display("FAIL mid_noack: got %b expected 0000", {i_ack, d_ack, i_err, d_err}); end
    reset = 1'b0;
    tick();
    n_checks++; if ({mem_start, grant_id} !== 2'b11 || mem_addr !== 32'h60) begin n_fail++; $display("FAIL post_grant: got %b/%h expected 11/00000060", {mem_start, grant_id}, mem_addr); end
    mem_done = 1'b1; mem_rdata = 32'h0000600D;
    tick();
    n_checks++; if ({d_ack, d_rdata} !== {1'b1, 32'h0000600D}) begin n_fail++; $display("FAIL post_read: got %b/%h expected 1/0000600d", d_ack, d_rdata); end
    mem_done = 1'b0; d_req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_done = 1'b0; mem_rdata = '0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_timeout();
    test_done_last_cycle();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
